// File: rtl/dual_port_ram_disp.sv
// dual_port_ram_disp: true dual-port RAM with registered reads, deterministic
// write-collision and read-during-write behaviour, a clear sequence after
// reset, and a 4-digit multiplexed seven-segment display of both ports.
module dual_port_ram_disp #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 4,
    parameter int RDW_MODE = 0,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic              oe_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              we_b,
    input  logic              oe_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              busy,
    output logic              collision,
    output logic [3:0]        sm_wei,
    output logic [7:0]        sm_duan
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              wr_collide;
    logic [DIV_W-1:0]  div_cnt;
    logic [1:0]        digit;
    logic [3:0]        nibble;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    assign busy       = (state == CLEAR);
    assign wr_collide = we_a && we_b && (addr_a == addr_b);

    // State register; reset always restarts the clear sequence
    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_next;
    end

    // Leave CLEAR on the edge that wipes the last word
    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_addr == '1) state_next = RUN;
    end

    // Clear address walks through every word while clearing, parked at 0 in reset
    always_ff @(posedge clk) begin
        if (rst)                 clr_addr <= '0;
        else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
    end

    // Memory writes; port A is written last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_addr] <= '0;
            end else begin
                if (we_b) mem[addr_b] <= din_b;
                if (we_a) mem[addr_a] <= din_a;
            end
        end
    end

    // Read data source: old contents, or the word being stored when forwarding new data
    always_comb begin
        rd_a = mem[addr_a];
        rd_b = mem[addr_b];
        if (RDW_MODE != 0) begin
            if (we_b && addr_b == addr_a) rd_a = din_b;
            if (we_a)                     rd_a = din_a;
            if (we_b)                     rd_b = din_b;
            if (we_a && addr_a == addr_b) rd_b = din_a;
        end
    end

    // Registered read ports and collision flag, held at zero while clearing
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) begin
            dout_a    <= '0;
            dout_b    <= '0;
            collision <= 1'b0;
        end else begin
            dout_a    <= oe_a ? rd_a : '0;
            dout_b    <= oe_b ? rd_b : '0;
            collision <= wr_collide;
        end
    end

    // Scan divider: each digit stays selected for SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            digit   <= 2'd0;
        end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            digit   <= digit + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Pick the low nibble shown by the current digit, zero-extending narrow fields
    always_comb begin
        nibble = 4'h0;
        case (digit)
            2'd0:    nibble = 4'(dout_a);
            2'd1:    nibble = 4'(dout_b);
            2'd2:    nibble = 4'(addr_a);
            default: nibble = 4'(addr_b);
        endcase
    end

    // Registered digit select and segment pattern, both active-low
    always_ff @(posedge clk) begin
        if (rst) begin
            sm_wei  <= 4'hF;
            sm_duan <= 8'hFF;
        end else begin
            sm_wei  <= ~(4'b0001 << digit);
            sm_duan <= hex_to_seg(nibble);
        end
    end

endmodule

// File: tb/tb_dual_port_ram_disp.sv
// tb_dual_port_ram_disp: drives one RDW_MODE=0 and one RDW_MODE=1 instance with
// identical stimulus and compares both against an array-based reference model.
module tb_dual_port_ram_disp;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst;
    logic       we_a, oe_a, we_b, oe_b;
    logic [3:0] addr_a, addr_b, din_a, din_b;

    logic [3:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic       busy0, busy1, coll0, coll1;
    logic [3:0] wei0, wei1;
    logic [7:0] duan0, duan1;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] wei_tbl [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};

    logic       model_valid = 1'b0;
    logic [3:0] mem_m [16];
    logic       busy_m;
    logic       coll_m;
    int         clr_pos;
    int         scan_t;
    logic [3:0] dout_a_m [2];
    logic [3:0] dout_b_m [2];
    logic [3:0] wei_m [2];
    logic [7:0] duan_m [2];

    dual_port_ram_disp #(.DATA_W(4), .ADDR_W(4), .RDW_MODE(0), .SCAN_DIV(SCAN_DIV)) dut0 (
        .clk(clk), .rst(rst),
        .we_a(we_a), .oe_a(oe_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0),
        .we_b(we_b), .oe_b(oe_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0),
        .busy(busy0), .collision(coll0), .sm_wei(wei0), .sm_duan(duan0)
    );

    dual_port_ram_disp #(.DATA_W(4), .ADDR_W(4), .RDW_MODE(1), .SCAN_DIV(SCAN_DIV)) dut1 (
        .clk(clk), .rst(rst),
        .we_a(we_a), .oe_a(oe_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1),
        .we_b(we_b), .oe_b(oe_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1),
        .busy(busy1), .collision(coll1), .sm_wei(wei1), .sm_duan(duan1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic wa, input logic oa, input logic [3:0] aa, input logic [3:0] da,
                                 input logic wb, input logic ob, input logic [3:0] ab, input logic [3:0] db);
        we_a = wa; oe_a = oa; addr_a = aa; din_a = da;
        we_b = wb; oe_b = ob; addr_b = ab; din_b = db;
        @(posedge clk);
        #2;
    endtask

    // Reference model: one step per rising edge, reads either the pre-write or post-write array
    task automatic model_edge();
        logic [3:0] old_mem [16];
        logic [3:0] nib;
        int         dig;
        if (rst) begin
            model_valid = 1'b1;
            busy_m      = 1'b1;
            coll_m      = 1'b0;
            clr_pos     = 0;
            scan_t      = 0;
            for (int m = 0; m < 2; m++) begin
                dout_a_m[m] = 4'h0;
                dout_b_m[m] = 4'h0;
                wei_m[m]    = 4'hF;
                duan_m[m]   = 8'hFF;
            end
            return;
        end
        if (!model_valid) return;
        dig = (scan_t / SCAN_DIV) % 4;
        for (int m = 0; m < 2; m++) begin
            case (dig)
                0:       nib = dout_a_m[m];
                1:       nib = dout_b_m[m];
                2:       nib = addr_a;
                default: nib = addr_b;
            endcase
            wei_m[m]  = wei_tbl[dig];
            duan_m[m] = seg_tbl[nib];
        end
        scan_t++;
        if (busy_m) begin
            mem_m[clr_pos] = 4'h0;
            clr_pos++;
            if (clr_pos == 16) busy_m = 1'b0;
            coll_m = 1'b0;
            for (int m = 0; m < 2; m++) begin
                dout_a_m[m] = 4'h0;
                dout_b_m[m] = 4'h0;
            end
        end else begin
            old_mem = mem_m;
            if (we_b) mem_m[addr_b] = din_b;
            if (we_a) mem_m[addr_a] = din_a;
            coll_m      = we_a && we_b && (addr_a == addr_b);
            dout_a_m[0] = oe_a ? old_mem[addr_a] : 4'h0;
            dout_b_m[0] = oe_b ? old_mem[addr_b] : 4'h0;
            dout_a_m[1] = oe_a ? mem_m[addr_a] : 4'h0;
            dout_b_m[1] = oe_b ? mem_m[addr_b] : 4'h0;
        end
    endtask

    // Advance the model on every rising edge using the inputs the DUTs sample
    always @(posedge clk) model_edge();

    // Compare every output of both instances against the model on each falling edge
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("busy0", busy0, busy_m);
            checkOutput("busy1", busy1, busy_m);
            checkOutput("coll0", coll0, coll_m);
            checkOutput("coll1", coll1, coll_m);
            checkOutput("dout_a0", dout_a0, dout_a_m[0]);
            checkOutput("dout_b0", dout_b0, dout_b_m[0]);
            checkOutput("dout_a1", dout_a1, dout_a_m[1]);
            checkOutput("dout_b1", dout_b1, dout_b_m[1]);
            checkOutput("wei0", wei0, wei_m[0]);
            checkOutput("wei1", wei1, wei_m[1]);
            checkOutput("duan0", duan0, duan_m[0]);
            checkOutput("duan1", duan1, duan_m[1]);
        end
    end

    // Count busy cycles while reading rd_addr, then confirm the word reads back as zero
    task automatic waitClear(input logic [3:0] rd_addr);
        int cnt = 0;
        while (busy0 && cnt < 40) begin
            checkOutput("clear_dout_a0", dout_a0, 0);
            checkOutput("clear_dout_a1", dout_a1, 0);
            cnt++;
            applyStimulus(1'b0, 1'b1, rd_addr, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        end
        checkOutput("busy_len", cnt, 16);
        applyStimulus(1'b0, 1'b1, rd_addr, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("post_clear_rd0", dout_a0, 0);
        checkOutput("post_clear_rd1", dout_a1, 0);
    endtask

    initial begin
        logic [3:0] exp_duan;
        int         wei_cnt [4];
        logic       wa, oa, wb, ob;
        logic [3:0] aa, ab;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("reset_busy", busy0, 1);
        checkOutput("reset_wei", wei0, 4'hF);
        checkOutput("reset_duan", duan0, 8'hFF);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        rst = 1'b0;
        waitClear(4'h0);

        $display("[TB] clear sequence with preloaded word");
        applyStimulus(1'b1, 1'b0, 4'h5, 4'h9, 1'b0, 1'b0, 4'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("preload_rd", dout_a0, 4'h9);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        rst = 1'b0;
        waitClear(4'h5);

        $display("[TB] basic read/write");
        applyStimulus(1'b1, 1'b0, 4'h2, 4'h3, 1'b0, 1'b0, 4'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h2, 4'h0);
        checkOutput("basic_rd_b0", dout_b0, 4'h3);
        checkOutput("basic_rd_b1", dout_b1, 4'h3);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 4'h0);
        checkOutput("basic_oe_off", dout_b0, 4'h0);

        $display("[TB] write collision");
        applyStimulus(1'b1, 1'b0, 4'h9, 4'h7, 1'b1, 1'b0, 4'h9, 4'h4);
        checkOutput("coll_pulse", coll0, 1);
        applyStimulus(1'b0, 1'b1, 4'h9, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("coll_drop", coll0, 0);
        checkOutput("coll_winner", dout_a0, 4'h7);

        $display("[TB] read during write");
        applyStimulus(1'b1, 1'b0, 4'h1, 4'h2, 1'b0, 1'b0, 4'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h1, 4'h6, 1'b0, 1'b1, 4'h1, 4'h0);
        checkOutput("rdw_old", dout_b0, 4'h2);
        checkOutput("rdw_new", dout_b1, 4'h6);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0, 4'h3, 4'hE, 1'b0, 1'b0, 4'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("pre_rst_rd", dout_a0, 4'hE);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'h3, 4'h5, 1'b0, 1'b0, 4'h0, 4'h0);
        rst = 1'b0;
        waitClear(4'h3);

        $display("[TB] display scan");
        applyStimulus(1'b1, 1'b0, 4'hF, 4'hA, 1'b1, 1'b0, 4'h0, 4'h3);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) wei_cnt[k] = 0;
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);
            case (wei_m[0])
                4'hE:    exp_duan = 4'h0;
                4'hD:    exp_duan = 4'h1;
                4'hB:    exp_duan = 4'h2;
                default: exp_duan = 4'h3;
            endcase
            case (exp_duan)
                4'h0:    checkOutput("scan_duan_d0", duan0, 8'h88);
                4'h1:    checkOutput("scan_duan_d1", duan0, 8'hB0);
                4'h2:    checkOutput("scan_duan_d2", duan0, 8'h8E);
                default: checkOutput("scan_duan_d3", duan0, 8'hC0);
            endcase
            case (wei0)
                4'hE:    wei_cnt[0]++;
                4'hD:    wei_cnt[1]++;
                4'hB:    wei_cnt[2]++;
                4'h7:    wei_cnt[3]++;
                default: ;
            endcase
        end
        checkOutput("scan_len_d0", wei_cnt[0], SCAN_DIV);
        checkOutput("scan_len_d1", wei_cnt[1], SCAN_DIV);
        checkOutput("scan_len_d2", wei_cnt[2], SCAN_DIV);
        checkOutput("scan_len_d3", wei_cnt[3], SCAN_DIV);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            wa  = $urandom_range(0, 1) != 0;
            wb  = $urandom_range(0, 1) != 0;
            oa  = $urandom_range(0, 1) != 0;
            ob  = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 1) != 0) begin
                aa = 4'($urandom_range(0, 3));
                ab = 4'($urandom_range(0, 3));
            end else begin
                aa = 4'($urandom_range(0, 15));
                ab = 4'($urandom_range(0, 15));
            end
            applyStimulus(wa, oa, aa, 4'($urandom_range(0, 15)), wb, ob, ab, 4'($urandom_range(0, 15)));
        end
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog so the run always ends even if the directed sequence stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dual_port_ram_disp.md
# dual_port_ram_disp

Parametrised true dual-port RAM with registered read ports, deterministic collision handling, a power-on/reset clear sequence, and an integrated 4-digit multiplexed seven-segment driver. It succeeds the fixed 16x2 asynchronous dual-port board demo. Two independent request ports (A, B) share one clock. The display shows both read-data values and both addresses for lab-board inspection.

## Interface
Parameters:
- DATA_W, 4, data width per word (1..16); display shows bits [3:0], zero-extended if narrower
- ADDR_W, 4, address width; DEPTH = 2^ADDR_W words
- RDW_MODE, 0, read-during-write to same address: 0 = return old data, 1 = return new (written) data
- SCAN_DIV, 50000, clock cycles each display digit is lit (>=2)

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- we_a, oe_a  in  1 each  port A write enable / read enable
- addr_a  in  ADDR_W  port A address
- din_a  in  DATA_W  port A write data
- dout_a  out  DATA_W  port A registered read data
- we_b, oe_b, addr_b, din_b, dout_b: same as port A, for port B
- busy  out  1  high while the clear sequence runs; requests are ignored
- collision  out  1  one-cycle pulse: both ports wrote the same address
- sm_wei  out  4  digit selects, active-low, one-hot-low
- sm_duan  out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1

## Operation
- FSM states: CLEAR, RUN. rst=1 at an edge -> CLEAR, clr_addr=0, from any state (mid-operation reset restarts the clear).
- CLEAR: at each edge with rst=0, write 0 to mem[clr_addr] and increment. At the edge that writes DEPTH-1, go to RUN. While rst is held, clr_addr stays at 0.
- busy = 1 in CLEAR. In CLEAR, all we/oe inputs are ignored and dout_a/dout_b hold 0.
- RUN, write: at an edge with we_x=1, mem[addr_x] <= din_x.
- Write collision: we_a=we_b=1 and addr_a==addr_b. Port A's data is stored, and collision=1 for the following cycle. Otherwise collision=0.
- RUN, read: at an edge with oe_x=1, dout_x <= mem[addr_x]. At an edge with oe_x=0, dout_x <= 0.
- Read-during-write applies when a read address equals any write address in the same cycle, on the same port or across ports.
  - RDW_MODE=0: the read returns the pre-write contents.
  - RDW_MODE=1: the read returns the data actually stored (port A's data if there is a collision).
- we_x and oe_x may both be high on one port; the RDW rules apply.
- Display:
  - A div counter runs 0..SCAN_DIV-1. On wrap, the digit index increments 0->1->2->3->0.
  - Digit 0 = dout_a[3:0], 1 = dout_b[3:0], 2 = addr_a (low 4 bits), 3 = addr_b.
  - Digit d is lit with sm_wei bit d = 0, all other bits 1.
  - Active-low hex codes, 0..F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- The display runs in both states; it is not gated by busy.

## Timing
- Reset values (cycle after rst sampled):
  - dout_a = dout_b = 0, collision = 0, busy = 1
  - sm_wei = 4'b1111, sm_duan = 8'hFF
  - div counter = 0, digit = 0
- Clear length: rst deasserted before edge 1 -> edges 1..DEPTH clear. busy falls after edge DEPTH. The first accepted request is at edge DEPTH+1.
- Read latency: 1 cycle. The request sampled at edge n appears on dout after edge n.
- Write-to-read: a read at edge n+1 sees a write from edge n in both modes.
- collision: asserted exactly 1 cycle after the colliding edge.
- Display outputs are registered and reflect the current digit index one cycle late.
  - Digit 0 is first shown in the cycle after reset release.
  - Each digit is held for SCAN_DIV cycles.
  - The full refresh period is 4*SCAN_DIV cycles.
- Digit values track dout/addr continuously, sampled each cycle.
- Address wrap: no auto-increment; out-of-range addresses are impossible by width.

## Test plan
Parameters for all scenarios: DATA_W=4, ADDR_W=4, SCAN_DIV=4.
1. Clear sequence:
   - Stimulus: pre-load mem[5]=9, pulse rst one cycle, then oe_a=1, addr_a=5 during busy.
   - Required: busy is high for 16 cycles after rst release; dout_a stays 0; after busy falls, a read of addr 5 returns 0.
2. Basic read/write:
   - Stimulus: A writes 3 to addr 2, then B reads addr 2.
   - Required: dout_b=3 one cycle after the read edge; oe_b=0 on the next edge -> dout_b=0.
3. Write collision:
   - Stimulus: same edge, A writes 7 and B writes 4, both to addr 9.
   - Required: collision=1 for exactly one cycle; a later read of addr 9 gives 7.
4. Read-during-write:
   - Stimulus: mem[1]=2; on one edge A writes 6 to addr 1 while B reads addr 1.
   - Required: dout_b=2 with RDW_MODE=0; dout_b=6 with RDW_MODE=1.
5. Reset mid-operation:
   - Stimulus: assert rst while A is writing 5 to addr 3.
   - Required: no write to mem[3] at the rst edge; clear restarts at addr 0; busy lasts a full 16 cycles; mem[3] reads 0.
6. Display scan:
   - Stimulus: dout_a=A, dout_b=3, addr_a=F, addr_b=0.
   - Required: sm_wei cycles 1110, 1101, 1011, 0111, each for 4 cycles, with sm_duan = 88, B0, 8E, C0 respectively.
